// File: rtl/mem_stage_lsu.sv
// Memory stage of the 16-bit RISC pipeline: pass-through/constant write-back,
// word loads and stores over a req/ack bus with a watchdog timeout.
module mem_stage_lsu #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic [1:0]        mem_op,
    input  logic [DATA_W-1:0] mem_alu_out,
    input  logic [DATA_W-1:0] mem_reg2_val,
    input  logic [REG_W-1:0]  mem_fwd_reg,
    input  logic [DATA_W-1:0] mem_lb_const,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_reg,
    output logic              wb_en,
    output logic              dmem_err
);

    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_CONST = 2'b11;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             timeout_hit;
    logic             mem_access;

    assign timeout_hit = (count == LAST_CNT);
    assign mem_access  = mem_valid && (mem_op == OP_LOAD || mem_op == OP_STORE);

    // Stall is forced low during reset so upstream is released while the access is abandoned.
    always_comb begin
        mem_stall = 1'b0;
        if (!reset) begin
            if (state == IDLE)
                mem_stall = mem_access;
            else
                mem_stall = !dmem_ack && !timeout_hit;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_data    <= '0;
            wb_reg     <= '0;
            wb_en      <= 1'b0;
            dmem_err   <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        case (mem_op)
                            OP_PASS: begin
                                wb_data <= mem_alu_out;
                                wb_reg  <= mem_fwd_reg;
                                wb_en   <= 1'b1;
                            end
                            OP_CONST: begin
                                wb_data <= mem_lb_const;
                                wb_reg  <= mem_fwd_reg;
                                wb_en   <= 1'b1;
                            end
                            default: begin
                                dmem_req   <= 1'b1;
                                dmem_we    <= (mem_op == OP_STORE);
                                dmem_addr  <= mem_alu_out;
                                dmem_wdata <= mem_reg2_val;
                                count      <= '0;
                                state      <= WAIT;
                            end
                        endcase
                    end
                end
                WAIT: begin
                    // Ack takes priority over a coincident timeout.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        state    <= IDLE;
                        if (!dmem_we) begin
                            wb_data <= dmem_rdata;
                            wb_reg  <= mem_fwd_reg;
                            wb_en   <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                        state    <= IDLE;
                        dmem_err <= 1'b1;
                        if (!dmem_we)
                            wb_data <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
